bmult28x28_bitheap_compressor: RTL and testbench



---
 rtl/bmult28x28_pkg.sv | 17 +
 rtl/bitheap_fa.sv | 11 +
 rtl/bmult28x28_bitheap_compressor.sv | 163 ++++++++++++++++
 tb/tb_bmult28x28_bitheap_compressor.sv | 108 ++++++++++
 4 files changed

// File: rtl/bmult28x28_pkg.sv
// bmult28x28_pkg: shared column heights and bit-heap types for the 28x28 multiplier heap compressor
package bmult28x28_pkg;
  localparam int NUM_COLS = 56;
  localparam int OUT_W = 57;
  localparam int MAX_H = 15;
  localparam int NUM_STAGES = 6;
  localparam int COL_HEIGHT [0:NUM_COLS-1] = '{
    2, 1, 3, 2, 4, 3, 5, 4, 6, 5, 7, 6, 8, 7, 9, 8,
    10, 9, 11, 10, 12, 11, 13, 12, 14, 13, 15, 14, 15, 14, 13, 13,
    12, 12, 11, 11, 10, 10, 9, 9, 8, 8, 7, 7, 6, 6, 5, 5,
    4, 4, 3, 3, 2, 2, 1, 1
  };
  // Row count entering each 3:2 stage; each stage maps n rows to 2*(n/3)+n%3.
  localparam int STAGE_ROWS [0:NUM_STAGES] = '{15, 10, 7, 5, 4, 3, 2};
  typedef logic [MAX_H-1:0] heap_col_t;
  typedef logic [OUT_W-1:0] heap_row_t;
endpackage

// File: rtl/bitheap_fa.sv
// bitheap_fa: full adder (3:2 counter) used throughout the reduction tree
module bitheap_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/bmult28x28_bitheap_compressor.sv
// bmult28x28_bitheap_compressor: reduces the 56-column bit heap to a 57-bit sum, registered once
module bmult28x28_bitheap_compressor
  import bmult28x28_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [COL_HEIGHT[0]-1:0]  in_col0,
  input  logic [COL_HEIGHT[1]-1:0]  in_col1,
  input  logic [COL_HEIGHT[2]-1:0]  in_col2,
  input  logic [COL_HEIGHT[3]-1:0]  in_col3,
  input  logic [COL_HEIGHT[4]-1:0]  in_col4,
  input  logic [COL_HEIGHT[5]-1:0]  in_col5,
  input  logic [COL_HEIGHT[6]-1:0]  in_col6,
  input  logic [COL_HEIGHT[7]-1:0]  in_col7,
  input  logic [COL_HEIGHT[8]-1:0]  in_col8,
  input  logic [COL_HEIGHT[9]-1:0]  in_col9,
  input  logic [COL_HEIGHT[10]-1:0] in_col10,
  input  logic [COL_HEIGHT[11]-1:0] in_col11,
  input  logic [COL_HEIGHT[12]-1:0] in_col12,
  input  logic [COL_HEIGHT[13]-1:0] in_col13,
  input  logic [COL_HEIGHT[14]-1:0] in_col14,
  input  logic [COL_HEIGHT[15]-1:0] in_col15,
  input  logic [COL_HEIGHT[16]-1:0] in_col16,
  input  logic [COL_HEIGHT[17]-1:0] in_col17,
  input  logic [COL_HEIGHT[18]-1:0] in_col18,
  input  logic [COL_HEIGHT[19]-1:0] in_col19,
  input  logic [COL_HEIGHT[20]-1:0] in_col20,
  input  logic [COL_HEIGHT[21]-1:0] in_col21,
  input  logic [COL_HEIGHT[22]-1:0] in_col22,
  input  logic [COL_HEIGHT[23]-1:0] in_col23,
  input  logic [COL_HEIGHT[24]-1:0] in_col24,
  input  logic [COL_HEIGHT[25]-1:0] in_col25,
  input  logic [COL_HEIGHT[26]-1:0] in_col26,
  input  logic [COL_HEIGHT[27]-1:0] in_col27,
  input  logic [COL_HEIGHT[28]-1:0] in_col28,
  input  logic [COL_HEIGHT[29]-1:0] in_col29,
  input  logic [COL_HEIGHT[30]-1:0] in_col30,
  input  logic [COL_HEIGHT[31]-1:0] in_col31,
  input  logic [COL_HEIGHT[32]-1:0] in_col32,
  input  logic [COL_HEIGHT[33]-1:0] in_col33,
  input  logic [COL_HEIGHT[34]-1:0] in_col34,
  input  logic [COL_HEIGHT[35]-1:0] in_col35,
  input  logic [COL_HEIGHT[36]-1:0] in_col36,
  input  logic [COL_HEIGHT[37]-1:0] in_col37,
  input  logic [COL_HEIGHT[38]-1:0] in_col38,
  input  logic [COL_HEIGHT[39]-1:0] in_col39,
  input  logic [COL_HEIGHT[40]-1:0] in_col40,
  input  logic [COL_HEIGHT[41]-1:0] in_col41,
  input  logic [COL_HEIGHT[42]-1:0] in_col42,
  input  logic [COL_HEIGHT[43]-1:0] in_col43,
  input  logic [COL_HEIGHT[44]-1:0] in_col44,
  input  logic [COL_HEIGHT[45]-1:0] in_col45,
  input  logic [COL_HEIGHT[46]-1:0] in_col46,
  input  logic [COL_HEIGHT[47]-1:0] in_col47,
  input  logic [COL_HEIGHT[48]-1:0] in_col48,
  input  logic [COL_HEIGHT[49]-1:0] in_col49,
  input  logic [COL_HEIGHT[50]-1:0] in_col50,
  input  logic [COL_HEIGHT[51]-1:0] in_col51,
  input  logic [COL_HEIGHT[52]-1:0] in_col52,
  input  logic [COL_HEIGHT[53]-1:0] in_col53,
  input  logic [COL_HEIGHT[54]-1:0] in_col54,
  input  logic [COL_HEIGHT[55]-1:0] in_col55,
  output logic [OUT_W-1:0]          comp_out
);
  heap_col_t col [NUM_COLS];
  heap_row_t rows0 [MAX_H];
  heap_row_t sum_d;
  assign col[0]  = heap_col_t'(in_col0);
  assign col[1]  = heap_col_t'(in_col1);
  assign col[2]  = heap_col_t'(in_col2);
  assign col[3]  = heap_col_t'(in_col3);
  assign col[4]  = heap_col_t'(in_col4);
  assign col[5]  = heap_col_t'(in_col5);
  assign col[6]  = heap_col_t'(in_col6);
  assign col[7]  = heap_col_t'(in_col7);
  assign col[8]  = heap_col_t'(in_col8);
  assign col[9]  = heap_col_t'(in_col9);
  assign col[10] = heap_col_t'(in_col10);
  assign col[11] = heap_col_t'(in_col11);
  assign col[12] = heap_col_t'(in_col12);
  assign col[13] = heap_col_t'(in_col13);
  assign col[14] = heap_col_t'(in_col14);
  assign col[15] = heap_col_t'(in_col15);
  assign col[16] = heap_col_t'(in_col16);
  assign col[17] = heap_col_t'(in_col17);
  assign col[18] = heap_col_t'(in_col18);
  assign col[19] = heap_col_t'(in_col19);
  assign col[20] = heap_col_t'(in_col20);
  assign col[21] = heap_col_t'(in_col21);
  assign col[22] = heap_col_t'(in_col22);
  assign col[23] = heap_col_t'(in_col23);
  assign col[24] = heap_col_t'(in_col24);
  assign col[25] = heap_col_t'(in_col25);
  assign col[26] = heap_col_t'(in_col26);
  assign col[27] = heap_col_t'(in_col27);
  assign col[28] = heap_col_t'(in_col28);
  assign col[29] = heap_col_t'(in_col29);
  assign col[30] = heap_col_t'(in_col30);
  assign col[31] = heap_col_t'(in_col31);
  assign col[32] = heap_col_t'(in_col32);
  assign col[33] = heap_col_t'(in_col33);
  assign col[34] = heap_col_t'(in_col34);
  assign col[35] = heap_col_t'(in_col35);
  assign col[36] = heap_col_t'(in_col36);
  assign col[37] = heap_col_t'(in_col37);
  assign col[38] = heap_col_t'(in_col38);
  assign col[39] = heap_col_t'(in_col39);
  assign col[40] = heap_col_t'(in_col40);
  assign col[41] = heap_col_t'(in_col41);
  assign col[42] = heap_col_t'(in_col42);
  assign col[43] = heap_col_t'(in_col43);
  assign col[44] = heap_col_t'(in_col44);
  assign col[45] = heap_col_t'(in_col45);
  assign col[46] = heap_col_t'(in_col46);
  assign col[47] = heap_col_t'(in_col47);
  assign col[48] = heap_col_t'(in_col48);
  assign col[49] = heap_col_t'(in_col49);
  assign col[50] = heap_col_t'(in_col50);
  assign col[51] = heap_col_t'(in_col51);
  assign col[52] = heap_col_t'(in_col52);
  assign col[53] = heap_col_t'(in_col53);
  assign col[54] = heap_col_t'(in_col54);
  assign col[55] = heap_col_t'(in_col55);
  // Row r holds bit r of every column; columns shorter than r contribute zeros.
  always_comb
    for (int r = 0; r < MAX_H; r++) begin
      rows0[r] = '0;
      for (int c = 0; c < NUM_COLS; c++) rows0[r][c] = col[c][r];
    end
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int N = STAGE_ROWS[s];
    localparam int G = N / 3;
    heap_row_t src [MAX_H];
    heap_row_t nxt [MAX_H];
    if (s == 0) begin : g_first
      assign src = rows0;
    end else begin : g_chain
      assign src = g_stage[s-1].nxt;
    end
    for (genvar g = 0; g < G; g++) begin : g_csa
      for (genvar i = 0; i < OUT_W - 1; i++) begin : g_bit
        bitheap_fa u_fa (
          .a   (src[3*g][i]),
          .b   (src[3*g+1][i]),
          .cin (src[3*g+2][i]),
          .s   (nxt[2*g][i]),
          .cout(nxt[2*g+1][i+1])
        );
      end
      // The full sum fits in OUT_W bits, so the carry out of the top bit is always zero.
      assign nxt[2*g][OUT_W-1] = src[3*g][OUT_W-1] ^ src[3*g+1][OUT_W-1] ^ src[3*g+2][OUT_W-1];
      assign nxt[2*g+1][0] = 1'b0;
    end
    for (genvar r = 3 * G; r < N; r++) begin : g_pass
      assign nxt[2*G+r-3*G] = src[r];
    end
    for (genvar r = STAGE_ROWS[s+1]; r < MAX_H; r++) begin : g_zero
      assign nxt[r] = '0;
    end
  end
  assign sum_d = g_stage[NUM_STAGES-1].nxt[0] + g_stage[NUM_STAGES-1].nxt[1];
  always_ff @(posedge clk) comp_out <= rst ? '0 : sum_d;
endmodule

// File: tb/tb_bmult28x28_bitheap_compressor.sv
// tb_bmult28x28_bitheap_compressor: directed and random checks of the heap compressor against a popcount model
module tb_bmult28x28_bitheap_compressor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [14:0] col [56];
  logic [56:0] comp_out;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  bmult28x28_bitheap_compressor dut (
    .clk(clk), .rst(rst),
    .in_col0(col[0][1:0]),    .in_col1(col[1][0:0]),    .in_col2(col[2][2:0]),    .in_col3(col[3][1:0]),
    .in_col4(col[4][3:0]),    .in_col5(col[5][2:0]),    .in_col6(col[6][4:0]),    .in_col7(col[7][3:0]),
    .in_col8(col[8][5:0]),    .in_col9(col[9][4:0]),    .in_col10(col[10][6:0]),  .in_col11(col[11][5:0]),
    .in_col12(col[12][7:0]),  .in_col13(col[13][6:0]),  .in_col14(col[14][8:0]),  .in_col15(col[15][7:0]),
    .in_col16(col[16][9:0]),  .in_col17(col[17][8:0]),  .in_col18(col[18][10:0]), .in_col19(col[19][9:0]),
    .in_col20(col[20][11:0]), .in_col21(col[21][10:0]), .in_col22(col[22][12:0]), .in_col23(col[23][11:0]),
    .in_col24(col[24][13:0]), .in_col25(col[25][12:0]), .in_col26(col[26][14:0]), .in_col27(col[27][13:0]),
    .in_col28(col[28][14:0]), .in_col29(col[29][13:0]), .in_col30(col[30][12:0]), .in_col31(col[31][12:0]),
    .in_col32(col[32][11:0]), .in_col33(col[33][11:0]), .in_col34(col[34][10:0]), .in_col35(col[35][10:0]),
    .in_col36(col[36][9:0]),  .in_col37(col[37][9:0]),  .in_col38(col[38][8:0]),  .in_col39(col[39][8:0]),
    .in_col40(col[40][7:0]),  .in_col41(col[41][7:0]),  .in_col42(col[42][6:0]),  .in_col43(col[43][6:0]),
    .in_col44(col[44][5:0]),  .in_col45(col[45][5:0]),  .in_col46(col[46][4:0]),  .in_col47(col[47][4:0]),
    .in_col48(col[48][3:0]),  .in_col49(col[49][3:0]),  .in_col50(col[50][2:0]),  .in_col51(col[51][2:0]),
    .in_col52(col[52][1:0]),  .in_col53(col[53][1:0]),  .in_col54(col[54][0:0]),  .in_col55(col[55][0:0]),
    .comp_out(comp_out)
  );
  function automatic int hgt(input int c);
    if (c == 0) return 2;
    if (c == 1) return 1;
    if (c <= 27) return (c % 2 == 0) ? c / 2 + 2 : (c - 1) / 2 + 1;
    if (c == 28) return 15;
    if (c == 29) return 14;
    return 28 - c / 2;
  endfunction
  function automatic logic [56:0] model();
    logic [56:0] acc;
    acc = '0;
    for (int c = 0; c < 56; c++) acc += 57'($countones(col[c])) << c;
    return acc;
  endfunction
  task automatic fill(input int mode);
    for (int c = 0; c < 56; c++) begin
      logic [14:0] m;
      m = 15'((1 << hgt(c)) - 1);
      col[c] = mode == 0 ? 15'd0 : mode == 1 ? m : mode == 2 ? 15'd1 : 15'($urandom) & m;
    end
  endtask
  task automatic check(input string tag, input logic [56:0] got, input logic [56:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [56:0] exp;
    logic [56:0] golden;
    fill(0);
    tick();
    check("reset", comp_out, 57'h0);
    fill(1);
    tick();
    check("reset_priority", comp_out, 57'h0);
    rst = 1'b0;
    fill(0);
    tick();
    check("zeros", comp_out, 57'h0);
    col[0] = 15'b11;
    tick();
    check("col0", comp_out, 57'h2);
    fill(0);
    col[26] = 15'h7fff;
    tick();
    check("col26", comp_out, 57'h3C00_0000);
    fill(2);
    tick();
    check("one_per_col", comp_out, 57'h0FF_FFFF_FFFF_FFFF);
    golden = '0;
    for (int c = 0; c < 56; c++) golden += 57'(hgt(c)) << c;
    fill(1);
    tick();
    check("all_ones", comp_out, golden);
    check("all_ones_b56", 57'(comp_out[56]), 57'd1);
    fill(0);
    #3;
    check("hold", comp_out, golden);
    for (int n = 0; n < 20000; n++) begin
      fill(3);
      if (n == 10000) begin
        rst = 1'b1;
        tick();
        check("mid_reset", comp_out, 57'h0);
        rst = 1'b0;
        fill(3);
      end
      exp = model();
      tick();
      check(n == 10000 ? "resume" : "random", comp_out, exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
